// File: rtl/wb_write_port_pkg.sv
// Shared writeback/decode constants: datapath width, architectural register numbers,
// opcode/funct encodings used by the decoder, and the link-buffer state type.
package wb_write_port_pkg;

    localparam int DATA_W = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    // Major opcodes the decoder keys off when setting RegWrite/MemtoReg/Link_req.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic {
        LINK_IDLE    = 1'b0,
        LINK_PENDING = 1'b1
    } link_state_e;

    // A write only reaches the register file when enabled and not aimed at $0.
    function automatic logic is_real_dest(input logic reg_write, input logic [4:0] addr);
        return reg_write && (addr != REG_ZERO);
    endfunction

endpackage

// File: rtl/wb_link_buffer.sv
// One-entry park for jal link writes that lose the shared write port to pipeline writes.
// Latency: a request taken at edge N is offered from cycle N+1; drains when the port is free.
// Backpressure: busy while parked and the pipeline owns the port; requests then are dropped.
module wb_link_buffer #(
    parameter int DATA_W = 32
) (
    input  logic              core_clk,
    input  logic              arst_n,
    input  logic              link_req_vld,
    input  logic [DATA_W-1:0] link_req_dat,
    input  logic              wb_vld,
    output logic              link_vld,
    output logic [DATA_W-1:0] link_dat,
    output logic              busy,
    output logic              overflow
);
    import wb_write_port_pkg::*;

    link_state_e       state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              overflow_q, overflow_d;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= LINK_IDLE;
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        overflow_d = overflow_q;
        busy       = (state_q == LINK_PENDING) && wb_vld;

        case (state_q)
            LINK_IDLE: begin
                if (link_req_vld) begin
                    state_d = LINK_PENDING;
                    data_d  = link_req_dat;
                end
            end
            LINK_PENDING: begin
                if (!wb_vld) begin
                    // Port is ours this cycle: drain, and refill if a new jal arrives now.
                    if (link_req_vld) begin
                        data_d = link_req_dat;
                    end else begin
                        state_d = LINK_IDLE;
                    end
                end else if (link_req_vld) begin
                    overflow_d = 1'b1;
                end
            end
            default: begin
                state_d = LINK_IDLE;
            end
        endcase
    end

    assign link_vld = (state_q == LINK_PENDING);
    assign link_dat = data_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/wb_write_port.sv
// MEM/WB register, writeback data mux and shared register-file write port with jal link park.
// Latency: memory-stage write accepted at edge N is written at edge N+1; links drain when free.
// Backpressure: Busy_out asks decode to stall while a parked link is blocked by a pipeline write.
module wb_write_port #(
    parameter logic [4:0] LINK_REG = wb_write_port_pkg::REG_RA,
    parameter int         DATA_W   = wb_write_port_pkg::DATA_W
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic [4:0]        regD_addr_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] Mem_data_in,
    input  logic              Link_req_in,
    input  logic [DATA_W-1:0] Link_data_in,
    output logic              RegWrite_out,
    output logic [4:0]        regD_addr_out,
    output logic [DATA_W-1:0] regD_data_out,
    output logic              Busy_out,
    output logic              Overflow_out
);
    import wb_write_port_pkg::*;

    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic              link_vld;
    logic [DATA_W-1:0] link_dat;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Flush beats Stall; the result mux sits ahead of the register so the port is flop-driven.
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        if (Flush) begin
            wb_valid_d = 1'b0;
        end else if (!Stall) begin
            wb_valid_d = is_real_dest(RegWrite_in, regD_addr_in);
            wb_addr_d  = regD_addr_in;
            wb_data_d  = MemtoReg_in ? Mem_data_in : ALU_result_in;
        end
    end

    wb_link_buffer #(
        .DATA_W (DATA_W)
    ) u_link_buffer (
        .core_clk     (CLOCK),
        .arst_n       (RESET_N),
        .link_req_vld (Link_req_in),
        .link_req_dat (Link_data_in),
        .wb_vld       (wb_valid_q),
        .link_vld     (link_vld),
        .link_dat     (link_dat),
        .busy         (Busy_out),
        .overflow     (Overflow_out)
    );

    always_comb begin
        RegWrite_out  = 1'b0;
        regD_addr_out = '0;
        regD_data_out = '0;
        if (wb_valid_q) begin
            RegWrite_out  = 1'b1;
            regD_addr_out = wb_addr_q;
            regD_data_out = wb_data_q;
        end else if (link_vld) begin
            RegWrite_out  = 1'b1;
            regD_addr_out = LINK_REG;
            regD_data_out = link_dat;
        end
    end

endmodule

// File: tb/tb_wb_write_port.sv
// Directed vector table for the writeback port plus hand sequences for reset behaviour.
module tb_wb_write_port;

    logic        CLOCK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        RegWrite_in = 1'b0;
    logic        MemtoReg_in = 1'b0;
    logic [4:0]  regD_addr_in = '0;
    logic [31:0] ALU_result_in = '0;
    logic [31:0] Mem_data_in = '0;
    logic        Link_req_in = 1'b0;
    logic [31:0] Link_data_in = '0;
    logic        RegWrite_out;
    logic [4:0]  regD_addr_out;
    logic [31:0] regD_data_out;
    logic        Busy_out;
    logic        Overflow_out;

    int n_applied = 0;
    int n_bad = 0;

    always #5 CLOCK = ~CLOCK;

    wb_write_port dut (
        .CLOCK         (CLOCK),
        .RESET_N       (RESET_N),
        .Stall         (Stall),
        .Flush         (Flush),
        .RegWrite_in   (RegWrite_in),
        .MemtoReg_in   (MemtoReg_in),
        .regD_addr_in  (regD_addr_in),
        .ALU_result_in (ALU_result_in),
        .Mem_data_in   (Mem_data_in),
        .Link_req_in   (Link_req_in),
        .Link_data_in  (Link_data_in),
        .RegWrite_out  (RegWrite_out),
        .regD_addr_out (regD_addr_out),
        .regD_data_out (regD_data_out),
        .Busy_out      (Busy_out),
        .Overflow_out  (Overflow_out)
    );

    typedef struct {
        logic        stall, flush, rw, mtr;
        logic [4:0]  addr;
        logic [31:0] alu, mem;
        logic        lreq;
        logic [31:0] ldat;
        logic        e_rw;
        logic [4:0]  e_addr;
        logic [31:0] e_dat;
        logic        e_busy, e_ovf;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic st, input logic fl, input logic rw, input logic mtr,
                                input logic [4:0] a, input logic [31:0] alu, input logic [31:0] mem,
                                input logic lr, input logic [31:0] ld,
                                input logic erw, input logic [4:0] ea, input logic [31:0] ed,
                                input logic eb, input logic eo);
        vec_t v;
        v.stall = st; v.flush = fl; v.rw = rw; v.mtr = mtr; v.addr = a;
        v.alu = alu; v.mem = mem; v.lreq = lr; v.ldat = ld;
        v.e_rw = erw; v.e_addr = ea; v.e_dat = ed; v.e_busy = eb; v.e_ovf = eo;
        return v;
    endfunction

    task automatic check(input string name, input logic erw, input logic [4:0] ea,
                         input logic [31:0] ed, input logic eb, input logic eo);
        n_applied++;
        if (RegWrite_out !== erw || regD_addr_out !== ea || regD_data_out !== ed ||
            Busy_out !== eb || Overflow_out !== eo) begin
            n_bad++;
            $display("FAIL %s: got we=%b addr=%0d data=%h busy=%b ovf=%b, want we=%b addr=%0d data=%h busy=%b ovf=%b",
                     name, RegWrite_out, regD_addr_out, regD_data_out, Busy_out, Overflow_out,
                     erw, ea, ed, eb, eo);
        end
    endtask

    task automatic drive(input vec_t v);
        Stall = v.stall; Flush = v.flush; RegWrite_in = v.rw; MemtoReg_in = v.mtr;
        regD_addr_in = v.addr; ALU_result_in = v.alu; Mem_data_in = v.mem;
        Link_req_in = v.lreq; Link_data_in = v.ldat;
    endtask

    initial begin
        vec_t idle;
        idle = mk(0,0,0,0, 5'd0, 32'h0, 32'h0, 0, 32'h0, 0, 5'd0, 32'h0, 0, 0);

        //            st fl rw mt addr   alu           mem           lr ldat           erw ea     edat          eb eo
        vecs[0]  = mk(0,0,0,0, 5'd0,  32'h0,        32'h0,        0, 32'h0,        0, 5'd0,  32'h0,        0, 0);
        vecs[1]  = mk(0,0,1,0, 5'd8,  32'h1234,     32'h0,        0, 32'h0,        1, 5'd8,  32'h1234,     0, 0);
        vecs[2]  = mk(0,0,1,1, 5'd8,  32'h1111,     32'hCAFE,     0, 32'h0,        1, 5'd8,  32'hCAFE,     0, 0);
        vecs[3]  = mk(0,0,1,0, 5'd0,  32'hFFFF,     32'h0,        0, 32'h0,        0, 5'd0,  32'h0,        0, 0);
        vecs[4]  = mk(0,0,0,0, 5'd5,  32'h5,        32'h0,        0, 32'h0,        0, 5'd0,  32'h0,        0, 0);
        // collision: link parked behind two r9 writes, drains after the bubble
        vecs[5]  = mk(0,0,1,0, 5'd9,  32'hAAAA,     32'h0,        1, 32'h00400010, 1, 5'd9,  32'hAAAA,     1, 0);
        vecs[6]  = mk(0,0,1,0, 5'd9,  32'hBBBB,     32'h0,        0, 32'h0,        1, 5'd9,  32'hBBBB,     1, 0);
        vecs[7]  = mk(0,0,0,0, 5'd0,  32'h0,        32'h0,        0, 32'h0,        1, 5'd31, 32'h00400010, 0, 0);
        vecs[8]  = mk(0,0,0,0, 5'd0,  32'h0,        32'h0,        0, 32'h0,        0, 5'd0,  32'h0,        0, 0);
        // overflow: second request while busy is dropped, first link survives
        vecs[9]  = mk(0,0,1,0, 5'd10, 32'h10,       32'h0,        1, 32'h00400020, 1, 5'd10, 32'h10,       1, 0);
        vecs[10] = mk(0,0,1,0, 5'd10, 32'h11,       32'h0,        1, 32'hDEAD,     1, 5'd10, 32'h11,       1, 1);
        vecs[11] = mk(0,0,0,0, 5'd0,  32'h0,        32'h0,        0, 32'h0,        1, 5'd31, 32'h00400020, 0, 1);
        vecs[12] = mk(0,0,0,0, 5'd0,  32'h0,        32'h0,        0, 32'h0,        0, 5'd0,  32'h0,        0, 1);
        // drain and refill on a free port
        vecs[13] = mk(0,0,0,0, 5'd0,  32'h0,        32'h0,        1, 32'h100,      1, 5'd31, 32'h100,      0, 1);
        vecs[14] = mk(0,0,0,0, 5'd0,  32'h0,        32'h0,        1, 32'h200,      1, 5'd31, 32'h200,      0, 1);
        vecs[15] = mk(0,0,0,0, 5'd0,  32'h0,        32'h0,        0, 32'h0,        0, 5'd0,  32'h0,        0, 1);
        // stall re-drives, flush beats stall, parked link untouched
        vecs[16] = mk(0,0,1,0, 5'd12, 32'hC0C0,     32'h0,        1, 32'h300,      1, 5'd12, 32'hC0C0,     1, 1);
        vecs[17] = mk(1,0,1,0, 5'd13, 32'hDDDD,     32'h0,        0, 32'h0,        1, 5'd12, 32'hC0C0,     1, 1);
        vecs[18] = mk(1,0,1,0, 5'd13, 32'hDDDD,     32'h0,        0, 32'h0,        1, 5'd12, 32'hC0C0,     1, 1);
        vecs[19] = mk(1,1,1,0, 5'd14, 32'hEEEE,     32'h0,        0, 32'h0,        1, 5'd31, 32'h300,      0, 1);
        vecs[20] = mk(0,0,0,0, 5'd0,  32'h0,        32'h0,        0, 32'h0,        0, 5'd0,  32'h0,        0, 1);
        vecs[21] = mk(0,1,1,0, 5'd15, 32'hF00D,     32'h0,        0, 32'h0,        0, 5'd0,  32'h0,        0, 1);
        vecs[22] = mk(0,0,1,0, 5'd16, 32'h1,        32'h0,        0, 32'h0,        1, 5'd16, 32'h1,        0, 1);
        vecs[23] = mk(1,0,0,0, 5'd0,  32'h0,        32'h0,        0, 32'h0,        1, 5'd16, 32'h1,        0, 1);
        vecs[24] = mk(0,0,0,0, 5'd0,  32'h0,        32'h0,        0, 32'h0,        0, 5'd0,  32'h0,        0, 1);
        // flush does not cancel a link taken in the same cycle
        vecs[25] = mk(0,1,0,0, 5'd0,  32'h0,        32'h0,        1, 32'h400,      1, 5'd31, 32'h400,      0, 1);
        vecs[26] = mk(0,0,0,0, 5'd0,  32'h0,        32'h0,        0, 32'h0,        0, 5'd0,  32'h0,        0, 1);

        #2;
        check("reset_hold", 0, 5'd0, 32'h0, 0, 0);
        @(negedge CLOCK);
        RESET_N = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            @(posedge CLOCK);
            #1;
            check($sformatf("vec%0d", i), vecs[i].e_rw, vecs[i].e_addr, vecs[i].e_dat,
                  vecs[i].e_busy, vecs[i].e_ovf);
        end

        // Async reset while a link is parked behind a pipeline write.
        drive(mk(0,0,1,0, 5'd20, 32'h7, 32'h0, 1, 32'h500, 0,5'd0,32'h0,0,0));
        @(posedge CLOCK);
        #1;
        check("pre_reset_busy", 1, 5'd20, 32'h7, 1, 1);
        drive(idle);
        #2;
        RESET_N = 1'b0;
        #1;
        check("async_reset", 0, 5'd0, 32'h0, 0, 0);
        @(negedge CLOCK);
        RESET_N = 1'b1;
        @(posedge CLOCK);
        #1;
        check("post_reset_idle", 0, 5'd0, 32'h0, 0, 0);

        // Buffer must be IDLE again: a fresh link drains then clears.
        drive(mk(0,0,0,0, 5'd0, 32'h0, 32'h0, 1, 32'h600, 0,5'd0,32'h0,0,0));
        @(posedge CLOCK);
        #1;
        check("post_reset_link", 1, 5'd31, 32'h600, 0, 0);
        drive(idle);
        @(posedge CLOCK);
        #1;
        check("post_reset_drain", 0, 5'd0, 32'h0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_bad);
        $finish;
    end

endmodule
